// File: rtl/dp_rr_arb_pkg.sv
// Shared definitions for the dual-grant round-robin arbiter: server FSM
// state encoding, the "no requester" index and the server count.
package dp_rr_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } srv_state_e;

    localparam int IDX_NONE = 0;
    localparam int NUM_SRV  = 2;

endpackage

// File: rtl/dp_rot_enc.sv
// Combinational dual-priority encoder on a pointer-rotated request vector.
// Returns the 1-based absolute indices of the first and second winners (0 = none).
module dp_rot_enc
    import dp_rr_arb_pkg::*;
#(
    parameter int N  = 12,
    parameter int IW = 4
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] first_o,
    output logic [IW-1:0] second_o
);

    localparam logic [IW-1:0] NONE = IW'(IDX_NONE);

    // rot[k] is the request at priority rank k: rank 0 is index ptr, then ptr-1, ...
    logic [N-1:0] rot;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rot
            localparam logic [IW-1:0] GI = IW'(gi);
            logic [IW-1:0] src;
            assign src     = (ptr_i > GI) ? (ptr_i - GI - IW'(1)) : (ptr_i + IW'(N - 1) - GI);
            assign rot[gi] = req_i[src];
        end
    endgenerate

    logic [IW-1:0] rank1;
    logic [IW-1:0] rank2;
    logic          valid1;
    logic          valid2;

    always_comb begin
        rank1  = '0;
        rank2  = '0;
        valid1 = 1'b0;
        valid2 = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (rot[k]) begin
                if (!valid1) begin
                    valid1 = 1'b1;
                    rank1  = IW'(k);
                end else if (!valid2) begin
                    valid2 = 1'b1;
                    rank2  = IW'(k);
                end
            end
        end
    end

    // Rank k maps back to absolute index ptr-k, wrapping below 1 up to N.
    function automatic logic [IW-1:0] unrotate(input logic [IW-1:0] p, input logic [IW-1:0] k);
        return (p > k) ? (p - k) : (p + IW'(N) - k);
    endfunction

    assign first_o  = valid1 ? unrotate(ptr_i, rank1) : NONE;
    assign second_o = valid2 ? unrotate(ptr_i, rank2) : NONE;

endmodule

// File: rtl/dp_rr_arb.sv
// Round-robin arbiter sharing two identical servers (A, B) among N requesters.
// Define DP_ARB_TIMEOUT_EN to add per-server busy timeouts with forced release.
module dp_rr_arb
    import dp_rr_arb_pkg::*;
#(
    parameter int N  = 12,
    parameter int IW = 4
`ifdef DP_ARB_TIMEOUT_EN
    ,
    parameter int TO_CYCLES = 8
`endif
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic          done_a,
    input  logic          done_b,
    output logic [IW-1:0] grant_a,
    output logic [IW-1:0] grant_b,
    output logic          timeout_a,
    output logic          timeout_b
);

    localparam logic [IW-1:0] NONE = IW'(IDX_NONE);
`ifdef DP_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYCLES + 1);
`endif

    logic [NUM_SRV-1:0]          done;
    logic [NUM_SRV-1:0]          idle;
    logic [NUM_SRV-1:0]          timeout;
    logic [NUM_SRV-1:0][IW-1:0]  grant;
    logic [NUM_SRV-1:0][IW-1:0]  new_idx;
    logic [N-1:0]                held;
    logic [N-1:0]                elig;
    logic [IW-1:0]               first_idx;
    logic [IW-1:0]               second_idx;
    logic [IW-1:0]               last_idx;
    logic [IW-1:0]               ptr_q;
    logic [IW-1:0]               ptr_d;

    assign done = {done_b, done_a};

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_held
            assign held[gi] = (grant[0] == IW'(gi + 1)) || (grant[1] == IW'(gi + 1));
        end
    endgenerate

    // An idle server holds 0, so masking by both grants only removes the busy server's index.
    assign elig = req & ~held;

    dp_rot_enc #(
        .N  (N),
        .IW (IW)
    ) u_enc (
        .req_i    (elig),
        .ptr_i    (ptr_q),
        .first_o  (first_idx),
        .second_o (second_idx)
    );

    assign new_idx[0] = idle[0] ? first_idx : NONE;
    assign new_idx[1] = !idle[1] ? NONE : (idle[0] ? second_idx : first_idx);

    // B's grant is always the lower-priority one when both issue together.
    assign last_idx = (new_idx[1] != NONE) ? new_idx[1] : new_idx[0];

    always_comb begin
        ptr_d = ptr_q;
        if (last_idx != NONE) begin
            ptr_d = (last_idx == IW'(1)) ? IW'(N) : (last_idx - IW'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= IW'(N);
        end else begin
            ptr_q <= ptr_d;
        end
    end

    generate
        for (gi = 0; gi < NUM_SRV; gi++) begin : g_srv
            srv_state_e    state_q;
            srv_state_e    state_d;
            logic [IW-1:0] grant_q;
            logic [IW-1:0] grant_d;
`ifdef DP_ARB_TIMEOUT_EN
            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;
            logic          to_q;
            logic          to_d;
`endif

            always_comb begin
                state_d = state_q;
                grant_d = grant_q;
`ifdef DP_ARB_TIMEOUT_EN
                cnt_d   = cnt_q;
                to_d    = 1'b0;
`endif
                case (state_q)
                    ST_IDLE: begin
                        if (new_idx[gi] != NONE) begin
                            state_d = ST_BUSY;
                            grant_d = new_idx[gi];
`ifdef DP_ARB_TIMEOUT_EN
                            cnt_d   = '0;
`endif
                        end
                    end
                    ST_BUSY: begin
                        if (done[gi]) begin
                            state_d = ST_IDLE;
                            grant_d = NONE;
`ifdef DP_ARB_TIMEOUT_EN
                        end else if (cnt_q == CW'(TO_CYCLES - 1)) begin
                            state_d = ST_IDLE;
                            grant_d = NONE;
                            to_d    = 1'b1;
                        end else begin
                            cnt_d   = cnt_q + CW'(1);
`endif
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        grant_d = NONE;
                    end
                endcase
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_q <= ST_IDLE;
                    grant_q <= NONE;
`ifdef DP_ARB_TIMEOUT_EN
                    cnt_q   <= '0;
                    to_q    <= 1'b0;
`endif
                end else begin
                    state_q <= state_d;
                    grant_q <= grant_d;
`ifdef DP_ARB_TIMEOUT_EN
                    cnt_q   <= cnt_d;
                    to_q    <= to_d;
`endif
                end
            end

            assign idle[gi]  = (state_q == ST_IDLE);
            assign grant[gi] = grant_q;
`ifdef DP_ARB_TIMEOUT_EN
            assign timeout[gi] = to_q;
`else
            assign timeout[gi] = 1'b0;
`endif
        end
    endgenerate

    assign grant_a   = grant[0];
    assign grant_b   = grant[1];
    assign timeout_a = timeout[0];
    assign timeout_b = timeout[1];

endmodule

// File: tb/tb_dp_rr_arb.sv
// Self-checking bench for dp_rr_arb: directed scenarios plus randomized traffic,
// all compared every cycle against a behavioural priority-list model.
module tb_dp_rr_arb;

    localparam int N  = 12;
    localparam int IW = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req;
    logic          done_a;
    logic          done_b;
    logic [IW-1:0] grant_a;
    logic [IW-1:0] grant_b;
    logic          timeout_a;
    logic          timeout_b;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Model state: held index per server (0 = idle), pointer, busy-cycle counts, pulses.
    int m_ga = 0, m_gb = 0, m_ptr = N, m_ca = 0, m_cb = 0, m_toa = 0, m_tob = 0;
    int na, nb, ta, tb, new_a, new_b;

    dp_rr_arb #(
        .N  (N),
        .IW (IW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .done_a    (done_a),
        .done_b    (done_b),
        .grant_a   (grant_a),
        .grant_b   (grant_b),
        .timeout_a (timeout_a),
        .timeout_b (timeout_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // nth requester (1-based) in priority order ptr, ptr-1, .., 1, N, .., ptr+1, skipping excl.
    function automatic int pick(input logic [N-1:0] r, input int excl, input int p, input int nth);
        int seen = 0;
        int idx;
        logic [N-1:0] sh;
        for (int k = 0; k < N; k++) begin
            idx = p - k;
            if (idx < 1) idx += N;
            sh = r >> (idx - 1);
            if (sh[0] && idx != excl) begin
                seen++;
                if (seen == nth) return idx;
            end
        end
        return 0;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_ga = 0; m_gb = 0; m_ptr = N; m_ca = 0; m_cb = 0; m_toa = 0; m_tob = 0;
        end else begin
            na = m_ga; nb = m_gb; ta = 0; tb = 0; new_a = 0; new_b = 0;
            if (m_ga == 0 && m_gb == 0) begin
                new_a = pick(req, 0, m_ptr, 1);
                new_b = pick(req, 0, m_ptr, 2);
            end else if (m_ga == 0) begin
                new_a = pick(req, m_gb, m_ptr, 1);
            end else if (m_gb == 0) begin
                new_b = pick(req, m_ga, m_ptr, 1);
            end
            if (m_ga != 0) begin
                if (done_a) na = 0;
`ifdef DP_ARB_TIMEOUT_EN
                else begin
                    m_ca++;
                    if (m_ca == TO) begin na = 0; ta = 1; end
                end
`endif
            end
            if (m_gb != 0) begin
                if (done_b) nb = 0;
`ifdef DP_ARB_TIMEOUT_EN
                else begin
                    m_cb++;
                    if (m_cb == TO) begin nb = 0; tb = 1; end
                end
`endif
            end
            if (new_a != 0) begin na = new_a; m_ca = 0; end
            if (new_b != 0) begin nb = new_b; m_cb = 0; end
            if (new_b != 0) m_ptr = new_b - 1;
            else if (new_a != 0) m_ptr = new_a - 1;
            if (m_ptr == 0) m_ptr = N;
            m_ga = na; m_gb = nb; m_toa = ta; m_tob = tb;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("grant_a", 32'(grant_a), 32'(m_ga));
            chk("grant_b", 32'(grant_b), 32'(m_gb));
            chk("timeout_a", 32'(timeout_a), 32'(m_toa));
            chk("timeout_b", 32'(timeout_b), 32'(m_tob));
            chk("distinct", 32'((grant_a != 0) && (grant_a == grant_b)), 0);
        end
    end

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req = '0; done_a = 1'b0; done_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_grant_a", 32'(grant_a), 0);
        chk("rst_grant_b", 32'(grant_b), 0);
        chk("rst_timeout_a", 32'(timeout_a), 0);

        // Two requests from reset: A gets 12, B gets 11, pointer moves to 10.
        reset = 1'b0; req = 12'hC00;
        @(negedge clk);
        $display("[TB] t1 req=c00 grant_a=%0d grant_b=%0d", grant_a, grant_b);
        chk("t1_grant_a", 32'(grant_a), 12);
        chk("t1_grant_b", 32'(grant_b), 11);
        chk("t1_model_ptr", 32'(m_ptr), 10);

        // Release A under full load: one idle cycle, then 10 (11 masked, 12 lower priority).
        req = 12'hFFF; done_a = 1'b1;
        @(negedge clk);
        done_a = 1'b0;
        $display("[TB] t2 release grant_a=%0d grant_b=%0d", grant_a, grant_b);
        chk("t2_gap_grant_a", 32'(grant_a), 0);
        chk("t2_gap_grant_b", 32'(grant_b), 11);
        @(negedge clk);
        $display("[TB] t2 regrant grant_a=%0d grant_b=%0d", grant_a, grant_b);
        chk("t2_grant_a", 32'(grant_a), 10);
        chk("t2_model_ptr", 32'(m_ptr), 9);

        // Both busy with no done: nothing moves.
`ifdef DP_ARB_TIMEOUT_EN
        repeat (4) @(negedge clk);
`else
        repeat (20) @(negedge clk);
`endif
        $display("[TB] t4 hold grant_a=%0d grant_b=%0d", grant_a, grant_b);
        chk("t4_grant_a", 32'(grant_a), 10);
        chk("t4_grant_b", 32'(grant_b), 11);
        chk("t4_model_ptr", 32'(m_ptr), 9);

        // Reset mid-operation aborts both grants.
        reset = 1'b1; req = '0;
        @(negedge clk);
        reset = 1'b0;
        $display("[TB] t5 reset grant_a=%0d grant_b=%0d", grant_a, grant_b);
        chk("t5_grant_a", 32'(grant_a), 0);
        chk("t5_grant_b", 32'(grant_b), 0);
        chk("t5_model_ptr", 32'(m_ptr), N);

        // Single request at index 1: pointer wraps to N; release stays idle with no requests.
        req = 12'h001;
        @(negedge clk);
        $display("[TB] t3 req=001 grant_a=%0d grant_b=%0d", grant_a, grant_b);
        chk("t3_grant_a", 32'(grant_a), 1);
        chk("t3_grant_b", 32'(grant_b), 0);
        chk("t3_model_ptr", 32'(m_ptr), 12);
        req = '0; done_a = 1'b1;
        @(negedge clk);
        done_a = 1'b0;
        chk("t3_release", 32'(grant_a), 0);
        repeat (3) @(negedge clk);
        $display("[TB] t3 idle grant_a=%0d", grant_a);
        chk("t3_stay_idle", 32'(grant_a), 0);

`ifdef DP_ARB_TIMEOUT_EN
        // Forced release after TO busy cycles.
        pulse_reset();
        req = 12'hC00;
        @(negedge clk);
        req = '0;
        chk("t6_grant_a", 32'(grant_a), 12);
        repeat (TO - 1) @(negedge clk);
        chk("t6_still_busy", 32'(grant_a), 12);
        chk("t6_no_pulse_yet", 32'(timeout_a), 0);
        @(negedge clk);
        $display("[TB] t6 timeout grant_a=%0d timeout_a=%0d", grant_a, timeout_a);
        chk("t6_forced_release", 32'(grant_a), 0);
        chk("t6_pulse", 32'(timeout_a), 1);
        @(negedge clk);
        chk("t6_pulse_end", 32'(timeout_a), 0);
        // done on the timeout edge wins: no pulse.
        pulse_reset();
        req = 12'hC00;
        @(negedge clk);
        req = '0;
        repeat (TO - 1) @(negedge clk);
        done_a = 1'b1;
        @(negedge clk);
        done_a = 1'b0;
        $display("[TB] t6 done-wins grant_a=%0d timeout_a=%0d", grant_a, timeout_a);
        chk("t6b_release", 32'(grant_a), 0);
        chk("t6b_no_pulse", 32'(timeout_a), 0);
`endif

        // Randomized traffic, checked every cycle by the compare process.
        pulse_reset();
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0: req = 12'($urandom);
                1: req = 12'($urandom & $urandom & $urandom);
                2: req = 12'hFFF;
                default: req = '0;
            endcase
            done_a = ($urandom_range(0, 3) == 0);
            done_b = ($urandom_range(0, 3) == 0);
            reset  = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        reset = 1'b0; done_a = 1'b0; done_b = 1'b0; req = '0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
